// File: rtl/partition_chk_pkg.sv
// Shared types and helpers for the partition sweep checker: FSM/mode encodings,
// maximal-length Galois LFSR tap table and a 16-bit popcount.
package partition_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_EXH  = 1'b0,
    MODE_LFSR = 1'b1
  } mode_e;

  // Right-shifting Galois toggle masks; bit (t-1) set for each polynomial tap t.
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] t;
    case (width)
      3:       t = 16'h0006;
      4:       t = 16'h000C;
      5:       t = 16'h0014;
      6:       t = 16'h0030;
      7:       t = 16'h0060;
      8:       t = 16'h00B8;
      9:       t = 16'h0110;
      10:      t = 16'h0240;
      11:      t = 16'h0500;
      12:      t = 16'h0829;
      13:      t = 16'h100D;
      14:      t = 16'h2015;
      15:      t = 16'h6000;
      16:      t = 16'hD008;
      default: t = 16'h0006;
    endcase
    return t;
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/partition_pattern_gen.sv
// Pattern source: exhaustive counter or Galois LFSR, plus the issued counter
// that flags the final pattern of the sweep.
module partition_pattern_gen
  import partition_chk_pkg::*;
#(
  parameter int IN_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            mode_i,
  input  logic [IN_W-1:0] seed_i,
  input  logic [IN_W:0]   num_vec_i,
  input  logic            issue_i,
  output logic [IN_W-1:0] pi_o,
  output logic            last_o,
  output logic            n_zero_o
);

  localparam logic [15:0]     TAPS16 = lfsr_taps(IN_W);
  localparam logic [IN_W-1:0] TAPS   = TAPS16[IN_W-1:0];
  localparam logic [IN_W:0]   N_EXH  = {1'b1, {IN_W{1'b0}}};
  localparam logic [IN_W:0]   N_MAX  = {1'b0, {IN_W{1'b1}}};

  logic [IN_W-1:0] pi_q, pi_d;
  logic [IN_W:0]   issued_q, issued_d;
  logic [IN_W:0]   n_q, n_d;
  mode_e           mode_q, mode_d;
  logic [IN_W-1:0] lfsr_next;

  assign lfsr_next = (pi_q >> 1) ^ (pi_q[0] ? TAPS : '0);
  assign last_o    = ((issued_q + {{IN_W{1'b0}}, 1'b1}) == n_q);
  assign n_zero_o  = (n_q == '0);
  assign pi_o      = pi_q;

  always_comb begin
    pi_d     = pi_q;
    issued_d = issued_q;
    n_d      = n_q;
    mode_d   = mode_q;
    if (load_i) begin
      mode_d   = mode_e'(mode_i);
      issued_d = '0;
      if (mode_i) begin
        pi_d = (seed_i == '0) ? IN_W'(1) : seed_i;
        n_d  = (num_vec_i > N_MAX) ? N_MAX : num_vec_i;
      end else begin
        pi_d = '0;
        n_d  = N_EXH;
      end
    end else if (issue_i) begin
      issued_d = issued_q + {{IN_W{1'b0}}, 1'b1};
      // The final pattern stays on pi after the sweep ends.
      if (!last_o) begin
        pi_d = (mode_q == MODE_LFSR) ? lfsr_next : pi_q + IN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pi_q     <= '0;
      issued_q <= '0;
      n_q      <= '0;
      mode_q   <= MODE_EXH;
    end else begin
      pi_q     <= pi_d;
      issued_q <= issued_d;
      n_q      <= n_d;
      mode_q   <= mode_d;
    end
  end

endmodule

// File: rtl/partition_sweep_checker.sv
// Sweep-and-compare engine: drives patterns to an approximate and an exact
// partition, aligns responses through a LAT-deep valid pipe and accumulates error metrics.
module partition_sweep_checker
  import partition_chk_pkg::*;
#(
  parameter int IN_W  = 7,
  parameter int OUT_W = 4,
  parameter int LAT   = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                mode,
  input  logic [IN_W-1:0]                     seed,
  input  logic [IN_W:0]                       num_vec,
  input  logic                                hold,
  output logic [IN_W-1:0]                     pi,
  output logic                                pi_valid,
  input  logic [OUT_W-1:0]                    po_approx,
  input  logic [OUT_W-1:0]                    po_exact,
  output logic                                busy,
  output logic                                done,
  output logic [IN_W:0]                       err_count,
  output logic [IN_W+1+$clog2(OUT_W+1)-1:0]   hd_sum,
  output logic [OUT_W-1:0]                    max_abs_err,
  output logic [1:0]                          dbg_state
);

  localparam int          ERR_W = IN_W + 1;
  localparam int          HD_W  = IN_W + 1 + $clog2(OUT_W + 1);
  localparam logic [3:0]  LAT_V = 4'(LAT);

  state_e     state_q, state_d;
  logic [3:0] drain_q, drain_d;
  logic       accept, issue, last, n_zero, cmp_valid;

  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign issue  = (state_q == ST_RUN) && !hold && !n_zero;

  partition_pattern_gen #(.IN_W(IN_W)) u_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept),
    .mode_i   (mode),
    .seed_i   (seed),
    .num_vec_i(num_vec),
    .issue_i  (issue),
    .pi_o     (pi),
    .last_o   (last),
    .n_zero_o (n_zero)
  );

  // drain_q counts the edges still owed to the valid pipe after the final issue.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (n_zero) begin
          // An empty sweep behaves as if its last issue happened at the start edge.
          if (LAT == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
            drain_d = LAT_V - 4'd1;
          end
        end else if (issue && last) begin
          state_d = ST_DRAIN;
          drain_d = LAT_V;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 4'd0) state_d = ST_DONE;
        else                 drain_d = drain_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  generate
    if (LAT == 0) begin : g_nopipe
      assign cmp_valid = issue;
    end else begin : g_pipe
      logic [LAT-1:0] vpipe_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vpipe_q <= '0;
        else        vpipe_q <= (vpipe_q << 1) | LAT'(issue);
      end
      assign cmp_valid = vpipe_q[LAT-1];
    end
  endgenerate

  logic [OUT_W-1:0] diff, abs_diff;
  logic             mismatch;
  logic [4:0]       pop;
  logic [ERR_W-1:0] err_q;
  logic [HD_W-1:0]  hd_q;
  logic [OUT_W-1:0] max_q;

  assign diff     = po_approx ^ po_exact;
  assign mismatch = |diff;
  assign pop      = popcount(16'(diff));
  assign abs_diff = (po_approx >= po_exact) ? (po_approx - po_exact) : (po_exact - po_approx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
      hd_q  <= '0;
      max_q <= '0;
    end else if (accept) begin
      err_q <= '0;
      hd_q  <= '0;
      max_q <= '0;
    end else if (cmp_valid) begin
      err_q <= err_q + ERR_W'(mismatch);
      hd_q  <= hd_q + HD_W'(pop);
      if (abs_diff > max_q) max_q <= abs_diff;
    end
  end

  assign pi_valid    = issue;
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign err_count   = err_q;
  assign hd_sum      = hd_q;
  assign max_abs_err = max_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_partition_sweep_checker.sv
// Bench for partition_sweep_checker: LAT=0 and LAT=2 instances, directed sweeps,
// expected run results queued at start and checked when done rises.
module tb_partition_sweep_checker;

  localparam int EW = 40;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       mode, hold, start0, start2;
  logic [6:0] seed;
  logic [7:0] num_vec;

  logic [6:0]  pi0, pi2;
  logic        pv0, pv2, busy0, busy2, done0, done2;
  logic [3:0]  pa0, pe0, pa2, pe2, max0, max2;
  logic [7:0]  err0, err2;
  logic [10:0] hd0, hd2;
  logic [1:0]  st0, st2;
  logic        model0;
  logic [3:0]  d1, d2;

  assign pe0 = pi0[3:0];
  assign pa0 = model0 ? (pi0[3:0] & 4'b1110) : pi0[3:0];
  always @(posedge clk) begin
    d1 <= pi2[3:0];
    d2 <= d1;
  end
  assign pe2 = d2;
  assign pa2 = 4'd0;

  partition_sweep_checker #(.IN_W(7), .OUT_W(4), .LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode), .seed(seed),
    .num_vec(num_vec), .hold(hold), .pi(pi0), .pi_valid(pv0),
    .po_approx(pa0), .po_exact(pe0), .busy(busy0), .done(done0),
    .err_count(err0), .hd_sum(hd0), .max_abs_err(max0), .dbg_state(st0)
  );

  partition_sweep_checker #(.IN_W(7), .OUT_W(4), .LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode), .seed(seed),
    .num_vec(num_vec), .hold(hold), .pi(pi2), .pi_valid(pv2),
    .po_approx(pa2), .po_exact(pe2), .busy(busy2), .done(done2),
    .err_count(err2), .hd_sum(hd2), .max_abs_err(max2), .dbg_state(st2)
  );

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int errors = 0;
  int checks = 0;
  int pops = 0;
  int start_edge0 = 0;
  int start_edge2 = 0;
  logic [EW-1:0] exp_q[$];
  logic [6:0]    pat_log[$];
  int            pv2_cnt = 0;
  logic          done0_p = 1'b0;
  logic          done2_p = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard monitor
  task automatic mon_pop(input bit inst, input int a_err, input int a_hd,
                         input int a_max, input int a_edge);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: instance %0d raised done with nothing expected", inst);
    end else begin
      e = exp_q.pop_front();
      check("done_instance", int'(inst), int'(e[39]));
      check("err_count", a_err, int'(e[38:31]));
      check("hd_sum", a_hd, int'(e[30:20]));
      check("max_abs_err", a_max, int'(e[19:16]));
      check("done_edge", a_edge, int'(e[15:0]));
      pops++;
    end
  endtask

  always @(negedge clk) begin
    if (pv0) pat_log.push_back(pi0);
    if (pv2) pv2_cnt++;
    if (done0 && !done0_p) mon_pop(1'b0, int'(err0), int'(hd0), int'(max0), edge_cnt - start_edge0);
    if (done2 && !done2_p) mon_pop(1'b1, int'(err2), int'(hd2), int'(max2), edge_cnt - start_edge2);
    done0_p = done0;
    done2_p = done2;
  end

  // driver: one sweep, with optional 5-cycle hold and one start pulse while busy
  task automatic run(input bit inst, input bit md, input logic [6:0] sd, input logic [7:0] nv,
                     input int e_err, input int e_hd, input int e_max, input int e_edge,
                     input int hold_at, input int pulse_at);
    int  p0;
    int  r;
    bit  got;
    p0 = pops;
    @(negedge clk);
    exp_q.push_back({inst, 8'(e_err), 11'(e_hd), 4'(e_max), 16'(e_edge)});
    pat_log.delete();
    pv2_cnt = 0;
    mode = md;
    seed = sd;
    num_vec = nv;
    if (inst) begin
      start2 = 1'b1;
      start_edge2 = edge_cnt + 1;
    end else begin
      start0 = 1'b1;
      start_edge0 = edge_cnt + 1;
    end
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      start2 = 1'b0;
      r = edge_cnt - (inst ? start_edge2 : start_edge0);
      hold = (hold_at >= 0) && (r >= hold_at) && (r < hold_at + 5);
      if (r == pulse_at) begin
        if (inst) start2 = 1'b1;
        else       start0 = 1'b1;
      end
      got = (pops != p0);
    end
    hold = 1'b0;
    start0 = 1'b0;
    start2 = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: no done within 400 cycles, expected done at edge %0d", e_edge);
      exp_q.delete();
    end
  endtask

  initial begin
    int zeros;
    int dups;
    rst_n = 1'b0;
    start0 = 1'b0;
    start2 = 1'b0;
    mode = 1'b0;
    hold = 1'b0;
    seed = '0;
    num_vec = '0;
    model0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pi", int'(pi0), 0);
    check("rst_pi_valid", int'(pv0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_err", int'(err0), 0);
    check("rst_hd", int'(hd2), 0);
    check("rst_max", int'(max2), 0);
    @(negedge clk);
    rst_n = 1'b1;

    model0 = 1'b0;
    run(1'b0, 1'b0, 7'd0, 8'd0, 0, 0, 0, 129, -1, -1);
    model0 = 1'b1;
    run(1'b0, 1'b0, 7'd0, 8'd0, 64, 64, 1, 129, -1, -1);
    run(1'b1, 1'b0, 7'd0, 8'd0, 120, 256, 15, 131, -1, -1);
    run(1'b0, 1'b0, 7'd0, 8'd0, 64, 64, 1, 134, 50, -1);

    model0 = 1'b0;
    run(1'b0, 1'b1, 7'd0, 8'd10, 0, 0, 0, 11, -1, -1);
    check("lfsr_count", pat_log.size(), 10);
    if (pat_log.size() > 0) check("lfsr_first", int'(pat_log[0]), 1);
    zeros = 0;
    dups = 0;
    for (int i = 0; i < pat_log.size(); i++) begin
      if (pat_log[i] == '0) zeros++;
      for (int j = i + 1; j < pat_log.size(); j++) begin
        if (pat_log[i] == pat_log[j]) dups++;
      end
    end
    check("lfsr_zero_patterns", zeros, 0);
    check("lfsr_duplicates", dups, 0);

    model0 = 1'b1;
    run(1'b0, 1'b0, 7'd0, 8'd0, 64, 64, 1, 129, -1, 30);
    run(1'b0, 1'b1, 7'd5, 8'd0, 0, 0, 0, 1, -1, -1);
    check("nv0_pi_valid_cycles", pat_log.size(), 0);
    run(1'b1, 1'b1, 7'd5, 8'd0, 0, 0, 0, 3, -1, -1);
    check("nv0_lat2_pi_valid_cycles", pv2_cnt, 0);
    run(1'b0, 1'b0, 7'd0, 8'd0, 64, 64, 1, 129, -1, 128);

    // reset in the middle of a stuck-LSB sweep
    @(negedge clk);
    mode = 1'b0;
    start0 = 1'b1;
    start_edge0 = edge_cnt + 1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("pre_reset_err", int'(err0), 20);
    check("pre_reset_busy", int'(busy0), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy0), 0);
    check("midrst_pi", int'(pi0), 0);
    check("midrst_pi_valid", int'(pv0), 0);
    check("midrst_err", int'(err0), 0);
    check("midrst_hd", int'(hd0), 0);
    check("midrst_max", int'(max0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 1'b0, 7'd0, 8'd0, 64, 64, 1, 129, -1, -1);

    check("leftover_expectations", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/partition_sweep_checker.md
# partition_sweep_checker

Parametrised on-chip sweep-and-compare engine for evaluating approximated circuit partitions.
- Drives an IN_W-bit pattern stream, exhaustive or LFSR-pseudorandom, into an approximate partition and its exact golden copy.
- Aligns both OUT_W-bit responses through a latency-matched valid pipe.
- Accumulates error metrics: mismatch count, Hamming-distance sum and maximum absolute error.
- Replaces per-partition exhaustive display testbenches with a synthesizable block that reports metrics over a sweep of any width.

## Interface
- IN_W, default 7: pattern width, legal 3..16.
- OUT_W, default 4: response width, legal 1..16.
- LAT, default 0: register stages in the DUT pipelines, legal 0..8.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle run request; honoured only in IDLE or DONE.
- mode  in  1  0 = exhaustive sweep, 1 = LFSR sweep; sampled with start.
- seed  in  IN_W  LFSR seed, sampled with start. A zero seed is replaced by 1.
- num_vec  in  IN_W+1  pattern count for mode 1, sampled with start. Clamped to 2^IN_W−1.
- hold  in  1  while high in RUN, no pattern is issued: a bubble enters the valid pipe and pi stays where it is.
- pi  out  IN_W  pattern to both DUTs; reset 0.
- pi_valid  out  1  pi is issued this cycle; reset 0.
- po_approx  in  OUT_W  approximate DUT response.
- po_exact  in  OUT_W  golden DUT response.
- busy  out  1  high in RUN and DRAIN; reset 0.
- done  out  1  level, high in DONE until the next accepted start; reset 0.
- err_count  out  IN_W+1  number of patterns with po_approx ≠ po_exact; reset 0.
- hd_sum  out  IN_W+1+$clog2(OUT_W+1)  sum of popcount(po_approx ^ po_exact); reset 0.
- max_abs_err  out  OUT_W  maximum unsigned |po_approx − po_exact|; reset 0.

## Operation
- States are IDLE → RUN → DRAIN → DONE; DONE → RUN on start.
- start in IDLE or DONE has these effects at that edge:
  - clear all metrics, done and the issued counter;
  - load pi with 0 (mode 0) or the seed (mode 1);
  - enter RUN.
- start in RUN or DRAIN is ignored.
- RUN:
  - pi_valid = !hold.
  - On an issuing edge, pi advances: +1 in mode 0, Galois LFSR step in mode 1. The issued counter increments.
  - After N patterns are issued, the state goes to DRAIN; pi holds its last value.
  - N is 2^IN_W in mode 0 and the clamped num_vec in mode 1.
  - If N = 0, RUN goes to DRAIN on the first edge.
- The valid pipe has depth LAT. The response for the pattern issued in cycle t is compared in cycle t+LAT and accumulated at the edge ending that cycle.
- Compare logic is registered once:
  - err_count increments on mismatch;
  - hd_sum adds the popcount;
  - max_abs_err takes the max of its current value and the absolute difference.
- Widths are sized so that no accumulator can overflow, so no saturation logic exists.
- DRAIN lasts until the valid pipe is empty, then goes to DONE. Metrics are stable and final in DONE.
- The LFSR is maximal-length. It never produces 0, so mode 1 never issues pattern 0.
- Reset mid-run forces IDLE, clears every output and flushes the valid pipe. The next start begins a fresh run.
- Metrics are valid only when done is high.

## Timing
- With start sampled at edge 0 and no hold:
  - pattern k is on pi during the cycle after edge k;
  - the last accumulation occurs at edge N+LAT;
  - done rises at edge N+LAT+1.
- Each hold cycle delays done by one edge.
- busy rises at edge 0 and falls at the same edge where done rises.
- Latency from a response to the metrics is 1 edge.

## Structure
- Package partition_chk_pkg contains:
  - the state enum;
  - the mode enum;
  - the function lfsr_taps(width), a maximal-length tap table for widths 3..16;
  - the function popcount.
- One sub-module, partition_pattern_gen, holds the mode-muxed counter/LFSR, the issued counter and the end-of-sweep flag.
- The valid pipe, compare stage and FSM live in the top module.

## Test plan
- Identical DUTs: IN_W=7, OUT_W=4, LAT=0, mode 0, po_approx = po_exact = pi[3:0].
  - Required: err_count 0, hd_sum 0, max_abs_err 0, done at edge 129.
- Stuck LSB: po_exact = pi[3:0], po_approx = pi[3:0] & 4'b1110.
  - Required: err_count 64, hd_sum 64, max_abs_err 1.
- All-zero approximation: po_approx = 0, po_exact = pi[3:0], LAT=2 with both models delayed 2 cycles.
  - Required: err_count 120, hd_sum 256, max_abs_err 15, done at edge 131.
- Hold and LFSR:
  - mode 0 with hold high for 5 cycles mid-run: same metrics as the stuck-LSB case, done 5 edges later;
  - mode 1, seed 0, num_vec 10: exactly 10 distinct nonzero pi values, first pi = 1, done at edge 11+LAT.
- Start edge cases:
  - num_vec 0 in mode 1: no pi_valid, done at edge LAT+1, metrics 0;
  - start pulsed while busy: no effect on the count or on done timing.
- Reset mid-run: rst_n low at edge 40 clears busy, pi, pi_valid and all metrics immediately. A new start then reproduces the stuck-LSB case's results.
